// File: rtl/multi_cycle_control.sv
// multi_cycle_control: Moore FSM sequencing the multi-cycle MIPS datapath
// (fetch, decode, execute, memory, write-back). Drives every datapath
// enable/select and ALUOp for the downstream ALU control decoder.
// Optional build macro: MEM_WAIT_EN -- FETCH/MEMRD/MEMWR stall on mem_ready.
// Parameter ILLEGAL_HALT: 1 = unknown opcode parks in HALT, 0 = skip it.

module multi_cycle_control #(
    parameter bit ILLEGAL_HALT = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic [1:0] ALUOp,
    output logic       illegal,
    output logic [3:0] state
);

    localparam int unsigned STATE_W = 4;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // Code 14 is intentionally absent; the next-state default recovers it.
    typedef enum logic [STATE_W-1:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_REXE   = 4'd7,
        S_RWB    = 4'd8,
        S_BEQEX  = 4'd9,
        S_ADDIEX = 4'd10,
        S_ANDIEX = 4'd11,
        S_IMMWB  = 4'd12,
        S_JEX    = 4'd13,
        S_HALT   = 4'd15
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   mem_go_c;

`ifdef MEM_WAIT_EN
    assign mem_go_c = mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign mem_go_c         = 1'b1;
`endif

    // State register; reset aborts any instruction (or stall) immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: opcode dispatch in DECODE, lw/sw split in MEMADR.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  if (mem_go_c) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_REXE;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_ANDI:      state_d = S_ANDIEX;
                    OP_J:         state_d = S_JEX;
                    default:      state_d = ILLEGAL_HALT ? S_HALT : S_FETCH;
                endcase
            end
            // IR is not written outside FETCH, so opcode is still valid here.
            S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_go_c) state_d = S_MEMWB;
            S_MEMWR:  if (mem_go_c) state_d = S_FETCH;
            S_MEMWB:  state_d = S_FETCH;
            S_REXE:   state_d = S_RWB;
            S_RWB:    state_d = S_FETCH;
            S_BEQEX:  state_d = S_FETCH;
            S_ADDIEX: state_d = S_IMMWB;
            S_ANDIEX: state_d = S_IMMWB;
            S_IMMWB:  state_d = S_FETCH;
            S_JEX:    state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase
    end

    // Outputs decoded from the state register only (plus the FETCH stall mask).
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        PCSource    = 2'b00;
        ALUOp       = 2'b00;
        illegal     = 1'b0;
        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                IRWrite = mem_go_c;
                ALUSrcB = 2'b01;
                PCWrite = mem_go_c;
            end
            S_DECODE: ALUSrcB = 2'b11;
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_REXE: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            S_RWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_BEQEX: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
            end
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_ANDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp   = 2'b11;
            end
            S_IMMWB: RegWrite = 1'b1;
            S_JEX: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
            S_HALT:  illegal = 1'b1;
            default: ;
        endcase
    end

    assign state = STATE_W'(state_q);

endmodule

// File: tb/tb_multi_cycle_control.sv
// Bench for multi_cycle_control: two instances (ILLEGAL_HALT 1 and 0) share
// inputs; a path-per-opcode reference model predicts states and outputs.

module tb_multi_cycle_control;

`ifdef MEM_WAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic       mem_ready;

    logic       PCWrite_a, PCWriteCond_a, IorD_a, MemRead_a, MemWrite_a, IRWrite_a;
    logic       MemtoReg_a, RegDst_a, RegWrite_a, ALUSrcA_a, illegal_a;
    logic [1:0] ALUSrcB_a, PCSource_a, ALUOp_a;
    logic [3:0] state_a;
    logic       PCWrite_b, PCWriteCond_b, IorD_b, MemRead_b, MemWrite_b, IRWrite_b;
    logic       MemtoReg_b, RegDst_b, RegWrite_b, ALUSrcA_b, illegal_b;
    logic [1:0] ALUSrcB_b, PCSource_b, ALUOp_b;
    logic [3:0] state_b;
    logic [16:0] out_a, out_b;

    int errors = 0;
    int checks = 0;
    int exp_q[$];
    logic [5:0] legal_ops [7];

    always #5 clk = ~clk;

    multi_cycle_control #(.ILLEGAL_HALT(1'b1)) dut_a (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite_a), .PCWriteCond(PCWriteCond_a), .IorD(IorD_a),
        .MemRead(MemRead_a), .MemWrite(MemWrite_a), .IRWrite(IRWrite_a),
        .MemtoReg(MemtoReg_a), .RegDst(RegDst_a), .RegWrite(RegWrite_a),
        .ALUSrcA(ALUSrcA_a), .ALUSrcB(ALUSrcB_a), .PCSource(PCSource_a),
        .ALUOp(ALUOp_a), .illegal(illegal_a), .state(state_a)
    );

    multi_cycle_control #(.ILLEGAL_HALT(1'b0)) dut_b (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite_b), .PCWriteCond(PCWriteCond_b), .IorD(IorD_b),
        .MemRead(MemRead_b), .MemWrite(MemWrite_b), .IRWrite(IRWrite_b),
        .MemtoReg(MemtoReg_b), .RegDst(RegDst_b), .RegWrite(RegWrite_b),
        .ALUSrcA(ALUSrcA_b), .ALUSrcB(ALUSrcB_b), .PCSource(PCSource_b),
        .ALUOp(ALUOp_b), .illegal(illegal_b), .state(state_b)
    );

    assign out_a = {PCWrite_a, PCWriteCond_a, IorD_a, MemRead_a, MemWrite_a, IRWrite_a,
                    MemtoReg_a, RegDst_a, RegWrite_a, ALUSrcA_a, ALUSrcB_a, PCSource_a,
                    ALUOp_a, illegal_a};
    assign out_b = {PCWrite_b, PCWriteCond_b, IorD_b, MemRead_b, MemWrite_b, IRWrite_b,
                    MemtoReg_b, RegDst_b, RegWrite_b, ALUSrcA_b, ALUSrcB_b, PCSource_b,
                    ALUOp_b, illegal_b};

    // Expected control word for a state, straight from the state/output table.
    function automatic logic [16:0] exp_out(input int s, input logic rdy);
        logic pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa, ill;
        logic [1:0] asb, pcs, aop;
        {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa, ill} = '0;
        asb = 2'b00; pcs = 2'b00; aop = 2'b00;
        case (s)
            1:  begin mr = 1; irw = rdy; pcw = rdy; asb = 2'b01; end
            2:  asb = 2'b11;
            3:  begin asa = 1; asb = 2'b10; end
            4:  begin mr = 1; iord = 1; end
            5:  begin rw = 1; m2r = 1; end
            6:  begin mw = 1; iord = 1; end
            7:  begin asa = 1; aop = 2'b10; end
            8:  begin rw = 1; rd = 1; end
            9:  begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
            10: begin asa = 1; asb = 2'b10; end
            11: begin asa = 1; asb = 2'b10; aop = 2'b11; end
            12: rw = 1;
            13: begin pcw = 1; pcs = 2'b10; end
            15: ill = 1;
            default: ;
        endcase
        return {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa, asb, pcs, aop, ill};
    endfunction

    // States visited after FETCH for one instruction, ending at the next FETCH.
    function automatic void fill_path(input logic [5:0] op, input bit halt);
        exp_q.delete();
        exp_q.push_back(2);
        case (op)
            OP_LW:   begin exp_q.push_back(3); exp_q.push_back(4); exp_q.push_back(5); end
            OP_SW:   begin exp_q.push_back(3); exp_q.push_back(6); end
            OP_R:    begin exp_q.push_back(7); exp_q.push_back(8); end
            OP_BEQ:  exp_q.push_back(9);
            OP_ADDI: begin exp_q.push_back(10); exp_q.push_back(12); end
            OP_ANDI: begin exp_q.push_back(11); exp_q.push_back(12); end
            OP_J:    exp_q.push_back(13);
            default: if (halt) exp_q.push_back(15);
        endcase
        if (exp_q[exp_q.size()-1] != 15) exp_q.push_back(1);
    endfunction

    function automatic bit is_legal(input logic [5:0] op);
        return op == OP_R || op == OP_J || op == OP_BEQ || op == OP_ADDI ||
               op == OP_ANDI || op == OP_LW || op == OP_SW;
    endfunction

    task automatic test_reset();
        rst = 1'b1; opcode = OP_R; mem_ready = 1'b1;
        #1;
        checks++;
        if (state_a !== 4'd0 || out_a !== 17'd0) begin
            errors++;
            $display("FAIL reset_idle_a: state=%0d outs=%h, expected 0/0", state_a, out_a);
        end
        checks++;
        if (state_b !== 4'd0 || out_b !== 17'd0) begin
            errors++;
            $display("FAIL reset_idle_b: state=%0d outs=%h, expected 0/0", state_b, out_b);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks++;
        if (state_a !== 4'd0 || out_a !== 17'd0) begin
            errors++;
            $display("FAIL reset_hold: state=%0d outs=%h, expected 0/0", state_a, out_a);
        end
        @(negedge clk);
        checks++;
        if (state_a !== 4'd1 || out_a !== exp_out(1, 1'b1)) begin
            errors++;
            $display("FAIL reset_fetch: state=%0d outs=%h, expected 1/%h",
                     state_a, out_a, exp_out(1, 1'b1));
        end
    endtask

    // Directed legal opcodes in a fixed order, then random legal opcodes.
    task automatic test_instr_stream(input int n_random);
        logic [5:0] op;
        int cur;
        bit rdy, stall;
        for (int i = 0; i < 7 + n_random; i++) begin
            op = (i < 7) ? legal_ops[i] : legal_ops[$urandom_range(0, 6)];
            opcode = op;
            fill_path(op, 1'b1);
            cur = 1;
            for (int k = 0; k < exp_q.size(); ) begin
                mem_ready = WAIT_EN ? ($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 1));
                #1;
                rdy = WAIT_EN ? mem_ready : 1'b1;
                checks++;
                if (state_a !== 4'(cur) || out_a !== exp_out(cur, rdy)) begin
                    errors++;
                    $display("FAIL stream_a op=%b: state=%0d outs=%h, expected %0d/%h",
                             op, state_a, out_a, cur, exp_out(cur, rdy));
                end
                checks++;
                if (state_b !== 4'(cur) || out_b !== exp_out(cur, rdy)) begin
                    errors++;
                    $display("FAIL stream_b op=%b: state=%0d outs=%h, expected %0d/%h",
                             op, state_b, out_b, cur, exp_out(cur, rdy));
                end
                stall = WAIT_EN && !mem_ready && (cur == 1 || cur == 4 || cur == 6);
                @(negedge clk);
                if (!stall) begin
                    cur = exp_q[k];
                    k++;
                end
            end
        end
        mem_ready = 1'b1;
    endtask

    // FETCH-to-FETCH clock counts with memory always ready.
    task automatic test_latency();
        int lat [7];
        int n;
        lat = '{5, 4, 4, 3, 4, 4, 3};
        mem_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            opcode = legal_ops[i];
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (state_a !== 4'd1 && n < 20);
            checks++;
            if (n != lat[i]) begin
                errors++;
                $display("FAIL latency op=%b: cycles=%0d, expected %0d", legal_ops[i], n, lat[i]);
            end
        end
    endtask

    // Unknown opcode: dut_a parks in HALT, dut_b skips back to FETCH.
    task automatic test_illegal(input logic [5:0] op);
        mem_ready = 1'b1;
        opcode = op;
        @(negedge clk);
        checks++;
        if (state_a !== 4'd2 || state_b !== 4'd2) begin
            errors++;
            $display("FAIL illegal_decode: states=%0d/%0d, expected 2/2", state_a, state_b);
        end
        @(negedge clk);
        checks++;
        if (state_b !== 4'd1) begin
            errors++;
            $display("FAIL illegal_skip: state=%0d, expected 1", state_b);
        end
        for (int c = 0; c < 20; c++) begin
            checks++;
            if (state_a !== 4'd15 || out_a !== exp_out(15, 1'b1)) begin
                errors++;
                $display("FAIL illegal_halt cyc=%0d: state=%0d outs=%h, expected 15/%h",
                         c, state_a, out_a, exp_out(15, 1'b1));
            end
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (state_a !== 4'd0 || out_a !== 17'd0) begin
            errors++;
            $display("FAIL halt_reset: state=%0d outs=%h, expected 0/0", state_a, out_a);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (state_a !== 4'd1 || state_b !== 4'd1) begin
            errors++;
            $display("FAIL halt_refetch: states=%0d/%0d, expected 1/1", state_a, state_b);
        end
    endtask

    // Async reset in REXE must kill the RWB write without waiting for a clock.
    task automatic test_reset_mid();
        mem_ready = 1'b1;
        opcode = OP_R;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (state_a !== 4'd7 || ALUOp_a !== 2'b10) begin
            errors++;
            $display("FAIL mid_rexe: state=%0d aluop=%b, expected 7/10", state_a, ALUOp_a);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (state_a !== 4'd0 || RegWrite_a !== 1'b0 || state_b !== 4'd0) begin
            errors++;
            $display("FAIL mid_reset: states=%0d/%0d regwrite=%b, expected 0/0/0",
                     state_a, state_b, RegWrite_a);
        end
        @(negedge clk);
        checks++;
        if (state_a !== 4'd0 || out_a !== 17'd0) begin
            errors++;
            $display("FAIL mid_reset_hold: state=%0d outs=%h, expected 0/0", state_a, out_a);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (state_a !== 4'd1) begin
            errors++;
            $display("FAIL mid_refetch: state=%0d, expected 1", state_a);
        end
    endtask

    initial begin
        logic [5:0] bad;
        legal_ops = '{OP_LW, OP_SW, OP_R, OP_BEQ, OP_ADDI, OP_ANDI, OP_J};
        test_reset();
        test_instr_stream(40);
        test_latency();
        test_illegal(6'b111111);
        do bad = 6'($urandom_range(0, 63)); while (is_legal(bad));
        test_illegal(bad);
        test_reset_mid();
        test_instr_stream(10);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/multi_cycle_control.md
Name: multi_cycle_control

Overview:
- Moore state machine that sequences the multi-cycle MIPS datapath: fetch, decode, execute, memory access and write-back.
- Sits directly upstream of the ALU control decoder. It drives ALUOp[1:0], which the decoder combines with funct to select the ALU operation.
- Also drives every datapath enable and mux select: PC, instruction register, memory, register file.

Parameters:
- ILLEGAL_HALT, default 1: 1 = an unknown opcode enters HALT until reset; 0 = an unknown opcode returns to FETCH, skipping the instruction.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- opcode  in  6  instr[31:26] from the instruction register
- mem_ready  in  1  memory handshake; used only with MEM_WAIT_EN
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load if ALU zero (beq)
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemRead  out  1  memory read strobe
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  instruction register load
- MemtoReg  out  1  write-back data select: 1 = MDR, 0 = ALUOut
- RegDst  out  1  destination select: 1 = rd, 0 = rt
- RegWrite  out  1  register file write
- ALUSrcA  out  1  ALU A select: 0 = PC, 1 = A register
- ALUSrcB  out  2  ALU B select: 00 = B, 01 = const 4, 10 = sign-extended imm, 11 = sign-extended imm << 2
- PCSource  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
- ALUOp  out  2  to ALU control: 00 = add, 01 = sub, 10 = use funct, 11 = and
- illegal  out  1  high while in HALT
- state  out  4  current state code, for debug

Behaviour:
- Reset and output timing
  - rst asserted at any time, including mid-instruction: state forced to IDLE (0) immediately.
  - In IDLE every output is 0, including ALUOp = 00 and illegal = 0.
  - IDLE -> FETCH on the first clk edge with rst low.
  - Outputs are a pure function of the state register. No output depends combinationally on opcode.
- State codes and asserted outputs (any output not listed is 0):
  - 0 IDLE: nothing asserted.
  - 1 FETCH: MemRead, IRWrite, ALUSrcB = 01, ALUOp = 00, PCWrite, PCSource = 00.
  - 2 DECODE: ALUSrcB = 11, ALUOp = 00 (branch target into ALUOut).
  - 3 MEMADR: ALUSrcA, ALUSrcB = 10, ALUOp = 00.
  - 4 MEMRD: MemRead, IorD.
  - 5 MEMWB: RegWrite, MemtoReg.
  - 6 MEMWR: MemWrite, IorD.
  - 7 REXE: ALUSrcA, ALUOp = 10.
  - 8 RWB: RegWrite, RegDst.
  - 9 BEQEX: ALUSrcA, ALUOp = 01, PCWriteCond, PCSource = 01.
  - 10 ADDIEX: ALUSrcA, ALUSrcB = 10, ALUOp = 00.
  - 11 ANDIEX: ALUSrcA, ALUSrcB = 10, ALUOp = 11.
  - 12 IMMWB: RegWrite.
  - 13 JEX: PCWrite, PCSource = 10.
  - 15 HALT: illegal.
- Transitions
  - FETCH -> DECODE.
  - DECODE dispatches on opcode:
    - 100011 (lw) or 101011 (sw) -> MEMADR
    - 000000 (R-type) -> REXE
    - 000100 (beq) -> BEQEX
    - 001000 (addi) -> ADDIEX
    - 001100 (andi) -> ANDIEX
    - 000010 (j) -> JEX
    - any other opcode -> HALT if ILLEGAL_HALT = 1, else FETCH
  - MEMADR -> MEMRD (lw) or MEMWR (sw). The opcode is re-read here; it is stable because IRWrite is 0.
  - MEMRD -> MEMWB.
  - REXE -> RWB.
  - ADDIEX and ANDIEX -> IMMWB.
  - MEMWB, MEMWR, RWB, IMMWB, BEQEX and JEX -> FETCH.
  - HALT -> HALT; only rst leaves it.
- Latency in clocks, FETCH to next FETCH:
  - lw 5
  - sw, R-type, addi, andi 4
  - beq, j 3
  - illegal opcode with ILLEGAL_HALT = 0: 2
- Value 14 is unused. If the state register ever holds it, the next state is FETCH.

Optional Feature:
- MEM_WAIT_EN
  - Defined: FETCH, MEMRD and MEMWR hold their state and all outputs while mem_ready = 0, and advance on the first edge with mem_ready = 1.
  - During a FETCH stall, PCWrite and IRWrite are masked to 0 until mem_ready = 1, so the PC is not incremented repeatedly.
  - rst still aborts a stall immediately.
  - Not defined: mem_ready is ignored and every state is single-cycle as listed above.

Test Plan:
- rst = 1, then release -> all outputs 0 in IDLE; next cycle state = 1 with MemRead = 1, IRWrite = 1, PCWrite = 1, ALUSrcB = 01, ALUOp = 00.
- lw (opcode 100011, instr 0x8C080004) -> state sequence 1, 2, 3, 4, 5, 1; MemtoReg = 1 and RegWrite = 1 only in state 5; IorD = 1 only in state 4.
- R-type then andi (opcode 001100) -> ALUOp = 10 in REXE; ALUOp = 11 in ANDIEX; RegDst = 1 in RWB; RegDst = 0 in IMMWB.
- beq (000100) then j (000010) -> each takes 3 cycles; BEQEX gives ALUOp = 01, PCWriteCond = 1, PCSource = 01; JEX gives PCWrite = 1, PCSource = 10.
- opcode 111111 -> ILLEGAL_HALT = 1: state 15 and illegal = 1 held for 20 cycles, then rst returns to IDLE; ILLEGAL_HALT = 0: back to FETCH after DECODE.
- MEM_WAIT_EN with mem_ready low for 3 cycles in MEMRD, plus rst pulsed mid-REXE -> MEMRD holds for 4 cycles total; rst forces IDLE on the same edge with no RWB write.
